// File: rtl/tcb_lite_pkg.sv
// Shared types and helpers for the TCB-lite misalignment bridge.
// The split FSM state type is only used when TCB_LITE_SPLIT_EN is defined.
package tcb_lite_pkg;

  typedef enum logic [0:0] {
    SPLIT_IDLE,
    SPLIT_HI
  } tcb_lite_split_t;

  // Byte-enable mask of a 1<<siz byte access starting at lane off.
  // Bits at and above BEN spill into the next aligned word (the HI half).
  function automatic logic [15:0] tcb_lite_siz2ben(input logic [1:0] siz, input logic [2:0] off);
    logic [15:0] msk;
    case (siz)
      2'd0:    msk = 16'h0001;
      2'd1:    msk = 16'h0003;
      2'd2:    msk = 16'h000f;
      default: msk = 16'h00ff;
    endcase
    return msk << off;
  endfunction

endpackage

// File: rtl/tcb_lite_lib_byte_rotate.sv
// Combinational byte-lane rotator; DIR=0 rotates toward higher lanes (left),
// DIR=1 toward lower lanes (right).
module tcb_lite_lib_byte_rotate #(
  parameter int unsigned DAT = 32,
  parameter bit          DIR = 1'b0
)(
  input  logic [DAT-1:0]              dat,
  input  logic [$clog2(DAT/8)-1:0]    off,
  output logic [DAT-1:0]              rot
);

  localparam int unsigned BEN = DAT/8;
  localparam int unsigned OFW = $clog2(BEN);

  logic [OFW-1:0] src;

  always_comb begin
    rot = '0;
    src = '0;
    for (int i = 0; i < int'(BEN); i++) begin
      src = DIR ? (OFW'(i) + off) : (OFW'(i) - off);
      rot[8*i +: 8] = dat[{src, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/tcb_lite_lib_misalign_split.sv
// TCB-lite bridge: CPU log-size requests to byte-enable memory requests.
// Define TCB_LITE_SPLIT_EN to split misaligned accesses into two aligned transfers;
// otherwise misaligned accesses are answered with an error.
module tcb_lite_lib_misalign_split
  import tcb_lite_pkg::*;
#(
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             sub_vld,
  input  logic             sub_wen,
  input  logic [ADR-1:0]   sub_adr,
  input  logic [1:0]       sub_siz,
  input  logic [DAT-1:0]   sub_wdt,
  output logic [DAT-1:0]   sub_rdt,
  output logic             sub_err,
  output logic             sub_rdy,
  output logic             man_vld,
  output logic             man_wen,
  output logic [ADR-1:0]   man_adr,
  output logic [DAT/8-1:0] man_ben,
  output logic [DAT-1:0]   man_wdt,
  input  logic [DAT-1:0]   man_rdt,
  input  logic             man_err,
  input  logic             man_rdy
);

  localparam int unsigned BEN = DAT/8;
  localparam int unsigned OFW = $clog2(BEN);

  logic [OFW-1:0] off;
  logic [15:0]    ben_ext;
  logic           ill;
  logic           mis;
  logic           rej;
  logic [ADR-1:0] adr_lo;
  logic           sub_hs;

  assign off     = sub_adr[OFW-1:0];
  assign ben_ext = tcb_lite_siz2ben(sub_siz, 3'(off));
  assign ill     = (sub_siz > 2'(OFW));
  assign mis     = |ben_ext[15:BEN];
  assign adr_lo  = {sub_adr[ADR-1:OFW], {OFW{1'b0}}};
  assign sub_hs  = sub_vld & sub_rdy;

  // Write data is lane-positioned once; both split halves pick their lanes via man_ben.
  tcb_lite_lib_byte_rotate #(.DAT(DAT), .DIR(1'b0)) u_wdt_rot (
    .dat (sub_wdt),
    .off (off),
    .rot (man_wdt)
  );

`ifdef TCB_LITE_SPLIT_EN
  tcb_lite_split_t state, state_nxt;
  logic [ADR-1:0]  adr_hi;
  logic            lo_hs;
  logic            split_hs;

  assign adr_hi = adr_lo + ADR'(BEN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SPLIT_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    man_vld   = 1'b0;
    man_wen   = sub_wen;
    man_adr   = adr_lo;
    man_ben   = ben_ext[BEN-1:0];
    sub_rdy   = 1'b0;
    rej       = ill;
    lo_hs     = 1'b0;
    split_hs  = 1'b0;
    case (state)
      SPLIT_IDLE: begin
        if (ill) begin
          sub_rdy = 1'b1;
        end else if (mis) begin
          man_vld = sub_vld;
          if (sub_vld && man_rdy) begin
            lo_hs     = 1'b1;
            state_nxt = SPLIT_HI;
          end
        end else begin
          man_vld = sub_vld;
          sub_rdy = man_rdy;
        end
      end
      SPLIT_HI: begin
        man_vld  = sub_vld;
        man_adr  = adr_hi;
        man_ben  = ben_ext[2*BEN-1:BEN];
        sub_rdy  = man_rdy;
        split_hs = sub_vld & man_rdy;
        if (sub_vld && man_rdy) state_nxt = SPLIT_IDLE;
      end
      default: state_nxt = SPLIT_IDLE;
    endcase
    if (!rst) begin
      man_vld  = 1'b0;
      sub_rdy  = 1'b0;
      lo_hs    = 1'b0;
      split_hs = 1'b0;
    end
  end
`else
  always_comb begin
    man_vld = 1'b0;
    man_wen = sub_wen;
    man_adr = adr_lo;
    man_ben = ben_ext[BEN-1:0];
    sub_rdy = 1'b0;
    rej     = ill | mis;
    if (rej) begin
      sub_rdy = 1'b1;
    end else begin
      man_vld = sub_vld;
      sub_rdy = man_rdy;
    end
    if (!rst) begin
      man_vld = 1'b0;
      sub_rdy = 1'b0;
    end
  end
`endif

  // ---- p1: response context registered at the CPU handshake ----
  logic           vld_p1;
  logic           rej_p1;
  logic [OFW-1:0] off_p1;
  logic [1:0]     siz_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      rej_p1 <= 1'b0;
      off_p1 <= '0;
      siz_p1 <= '0;
    end else begin
      vld_p1 <= sub_hs;
      if (sub_hs) begin
        rej_p1 <= rej;
        off_p1 <= off;
        siz_p1 <= sub_siz;
      end
    end
  end

  logic [DAT-1:0] rdt_mrg;
  logic           err_mrg;

`ifdef TCB_LITE_SPLIT_EN
  logic           split_p1;
  logic           lo_cap_p1;
  // ---- p2: LO half response held until the HI half returns ----
  logic [DAT-1:0] lo_rdt_p2;
  logic           lo_err_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      split_p1  <= 1'b0;
      lo_cap_p1 <= 1'b0;
      lo_rdt_p2 <= '0;
      lo_err_p2 <= 1'b0;
    end else begin
      lo_cap_p1 <= lo_hs;
      if (sub_hs) split_p1 <= split_hs;
      if (lo_cap_p1) begin
        lo_rdt_p2 <= man_rdt;
        lo_err_p2 <= man_err;
      end
    end
  end

  // LO owns lanes at and above the offset, HI the wrapped lanes below it.
  always_comb begin
    rdt_mrg = man_rdt;
    err_mrg = man_err;
    if (split_p1) begin
      err_mrg = man_err | lo_err_p2;
      for (int j = 0; j < int'(BEN); j++) begin
        if (j >= int'(off_p1)) rdt_mrg[8*j +: 8] = lo_rdt_p2[8*j +: 8];
      end
    end
  end
`else
  assign rdt_mrg = man_rdt;
  assign err_mrg = man_err;
`endif

  logic [DAT-1:0] rdt_rot;

  tcb_lite_lib_byte_rotate #(.DAT(DAT), .DIR(1'b1)) u_rdt_rot (
    .dat (rdt_mrg),
    .off (off_p1),
    .rot (rdt_rot)
  );

  always_comb begin
    sub_rdt = '0;
    sub_err = 1'b0;
    if (vld_p1) begin
      if (rej_p1) begin
        sub_err = 1'b1;
      end else begin
        sub_err = err_mrg;
        for (int k = 0; k < int'(BEN); k++) begin
          if (k < (1 << siz_p1)) sub_rdt[8*k +: 8] = rdt_rot[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_tcb_lite_lib_misalign_split.sv
// Directed bench for tcb_lite_lib_misalign_split with a small byte-lane memory responder.
// Split scenarios run only when TCB_LITE_SPLIT_EN is defined, reject scenarios otherwise.
module tb_tcb_lite_lib_misalign_split;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sub_vld = 1'b0;
  logic        sub_wen = 1'b0;
  logic [31:0] sub_adr = '0;
  logic [1:0]  sub_siz = '0;
  logic [31:0] sub_wdt = '0;
  logic [31:0] sub_rdt;
  logic        sub_err;
  logic        sub_rdy;
  logic        man_vld;
  logic        man_wen;
  logic [31:0] man_adr;
  logic [3:0]  man_ben;
  logic [31:0] man_wdt;
  logic [31:0] man_rdt = '0;
  logic        man_err = 1'b0;
  logic        man_rdy = 1'b1;

  logic [31:0] err_adr = 32'h0000_0001;
  logic [7:0]  mem [0:255];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  tcb_lite_lib_misalign_split #(.ADR(32), .DAT(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .sub_vld (sub_vld),
    .sub_wen (sub_wen),
    .sub_adr (sub_adr),
    .sub_siz (sub_siz),
    .sub_wdt (sub_wdt),
    .sub_rdt (sub_rdt),
    .sub_err (sub_err),
    .sub_rdy (sub_rdy),
    .man_vld (man_vld),
    .man_wen (man_wen),
    .man_adr (man_adr),
    .man_ben (man_ben),
    .man_wdt (man_wdt),
    .man_rdt (man_rdt),
    .man_err (man_err),
    .man_rdy (man_rdy)
  );

  // Memory: one-cycle read latency, byte-enabled writes, error on err_adr.
  always @(posedge clk) begin
    static bit loaded = 1'b0;
    logic [31:0] rd;
    rd = '0;
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h04] = 8'hEF; mem[8'h05] = 8'hBE; mem[8'h06] = 8'hAD; mem[8'h07] = 8'hDE;
      mem[8'h08] = 8'hBB;
      mem[8'h11] = 8'h01; mem[8'h12] = 8'h02; mem[8'h13] = 8'h03; mem[8'h14] = 8'h04;
      loaded = 1'b1;
    end
    man_err <= 1'b0;
    if (man_vld && man_rdy) begin
      for (int i = 0; i < 4; i++) begin
        rd[8*i +: 8] = mem[man_adr[7:0] + 8'(i)];
        if (man_wen && man_ben[i]) mem[man_adr[7:0] + 8'(i)] = man_wdt[8*i +: 8];
      end
      man_err <= (man_adr == err_adr);
    end
    man_rdt <= rd;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic req(input logic vld, input logic wen, input logic [31:0] adr,
                     input logic [1:0] siz, input logic [31:0] wdt);
    sub_vld = vld;
    sub_wen = wen;
    sub_adr = adr;
    sub_siz = siz;
    sub_wdt = wdt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset: outputs quiet even with a request pending
    @(negedge clk);
    req(1, 0, 32'h8000_0004, 2, 0);
    #1;
    chk("rst_man_vld", man_vld, 0);
    chk("rst_sub_rdy", sub_rdy, 0);
    chk("rst_sub_rdt", sub_rdt, 0);
    chk("rst_sub_err", sub_err, 0);
    @(negedge clk);
    req(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // aligned LW, then back-to-back LB and SB
    @(negedge clk);
    req(1, 0, 32'h8000_0004, 2, 0);
    #1;
    chk("lw_man_vld", man_vld, 1);
    chk("lw_man_adr", man_adr, 32'h8000_0004);
    chk("lw_man_ben", man_ben, 4'b1111);
    chk("lw_sub_rdy", sub_rdy, 1);
    @(negedge clk);
    req(1, 0, 32'h8000_0005, 0, 0);
    #1;
    chk("lw_sub_rdt", sub_rdt, 32'hDEAD_BEEF);
    chk("lw_sub_err", sub_err, 0);
    chk("lb_man_ben", man_ben, 4'b0010);
    chk("lb_sub_rdy", sub_rdy, 1);
    @(negedge clk);
    req(1, 1, 32'h8000_0007, 0, 32'h0000_00AA);
    #1;
    chk("lb_sub_rdt", sub_rdt, 32'h0000_00BE);
    chk("sb_man_ben", man_ben, 4'b1000);
    chk("sb_man_wen", man_wen, 1);
    chk("sb_wdt_lane3", man_wdt[31:24], 8'hAA);
    @(negedge clk);
    req(1, 0, 32'h8000_0004, 2, 0);
    @(negedge clk);
    req(0, 0, 0, 0, 0);
    #1;
    chk("sb_readback", sub_rdt, 32'hAAAD_BEEF);

    // LD is wider than the bus: rejected locally
    @(negedge clk);
    req(1, 0, 32'h8000_0000, 3, 0);
    #1;
    chk("ld_man_vld", man_vld, 0);
    chk("ld_sub_rdy", sub_rdy, 1);
    @(negedge clk);
    req(0, 0, 0, 0, 0);
    #1;
    chk("ld_sub_err", sub_err, 1);
    chk("ld_sub_rdt", sub_rdt, 0);
    @(negedge clk);
    #1;
    chk("ld_err_clear", sub_err, 0);

`ifdef TCB_LITE_SPLIT_EN
    // misaligned SW split into LO and HI
    @(negedge clk);
    req(1, 1, 32'h8000_0003, 2, 32'h1122_3344);
    #1;
    chk("sw_lo_adr", man_adr, 32'h8000_0000);
    chk("sw_lo_ben", man_ben, 4'b1000);
    chk("sw_lo_wdt", man_wdt[31:24], 8'h44);
    chk("sw_lo_rdy", sub_rdy, 0);
    @(negedge clk);
    #1;
    chk("sw_hi_adr", man_adr, 32'h8000_0004);
    chk("sw_hi_ben", man_ben, 4'b0111);
    chk("sw_hi_wdt", man_wdt[23:0], 24'h11_2233);
    chk("sw_hi_rdy", sub_rdy, 1);
    @(negedge clk);
    req(1, 0, 32'h8000_0004, 2, 0);
    #1;
    chk("sw_sub_err", sub_err, 0);
    @(negedge clk);
    req(0, 0, 0, 0, 0);
    #1;
    chk("sw_readback", sub_rdt, 32'hAA11_2233);

    // misaligned LH across words
    @(negedge clk);
    req(1, 0, 32'h8000_0007, 1, 0);
    #1;
    chk("lh_lo_adr", man_adr, 32'h8000_0004);
    chk("lh_lo_ben", man_ben, 4'b1000);
    chk("lh_lo_rdy", sub_rdy, 0);
    @(negedge clk);
    #1;
    chk("lh_hi_adr", man_adr, 32'h8000_0008);
    chk("lh_hi_ben", man_ben, 4'b0001);
    chk("lh_hi_rdy", sub_rdy, 1);
    @(negedge clk);
    req(0, 0, 0, 0, 0);
    #1;
    chk("lh_sub_rdt", sub_rdt, 32'h0000_BBAA);
    chk("lh_sub_err", sub_err, 0);

    // split with LO error and stalls in both halves
    @(negedge clk);
    err_adr = 32'h8000_0010;
    man_rdy = 1'b0;
    req(1, 0, 32'h8000_0011, 2, 0);
    #1;
    chk("st_lo_adr", man_adr, 32'h8000_0010);
    chk("st_lo_ben", man_ben, 4'b1110);
    @(negedge clk);
    #1;
    chk("st_lo_adr_hold", man_adr, 32'h8000_0010);
    chk("st_lo_ben_hold", man_ben, 4'b1110);
    chk("st_lo_vld_hold", man_vld, 1);
    @(negedge clk);
    man_rdy = 1'b1;
    #1;
    chk("st_lo_rdy", sub_rdy, 0);
    @(negedge clk);
    man_rdy = 1'b0;
    #1;
    chk("st_hi_adr", man_adr, 32'h8000_0014);
    chk("st_hi_ben", man_ben, 4'b0001);
    chk("st_hi_rdy_lo", sub_rdy, 0);
    chk("st_no_rsp", sub_err, 0);
    @(negedge clk);
    man_rdy = 1'b1;
    #1;
    chk("st_hi_adr_hold", man_adr, 32'h8000_0014);
    chk("st_hi_rdy", sub_rdy, 1);
    @(negedge clk);
    req(0, 0, 0, 0, 0);
    err_adr = 32'h0000_0001;
    #1;
    chk("st_sub_err", sub_err, 1);
    chk("st_sub_rdt", sub_rdt, 32'h0403_0201);

    // address wrap on HI, reset while HI is stalled
    @(negedge clk);
    req(1, 0, 32'hFFFF_FFFE, 2, 0);
    #1;
    chk("wr_lo_adr", man_adr, 32'hFFFF_FFFC);
    chk("wr_lo_ben", man_ben, 4'b1100);
    @(negedge clk);
    man_rdy = 1'b0;
    #1;
    chk("wr_hi_adr", man_adr, 32'h0000_0000);
    chk("wr_hi_ben", man_ben, 4'b0011);
    #2;
    rst = 1'b0;
    #1;
    chk("wr_rst_vld", man_vld, 0);
    chk("wr_rst_rdy", sub_rdy, 0);
    @(negedge clk);
    rst = 1'b1;
    man_rdy = 1'b1;
    req(0, 0, 0, 0, 0);
    #1;
    chk("wr_no_err", sub_err, 0);
    @(negedge clk);
    #1;
    chk("wr_no_rdt", sub_rdt, 0);
    req(1, 0, 32'h8000_0004, 2, 0);
    #1;
    chk("wr_idle_adr", man_adr, 32'h8000_0004);
    chk("wr_idle_ben", man_ben, 4'b1111);
    chk("wr_idle_rdy", sub_rdy, 1);
    @(negedge clk);
    req(0, 0, 0, 0, 0);
    #1;
    chk("wr_idle_rdt", sub_rdt, 32'hAA11_2233);
`else
    // misaligned LW rejected without forwarding
    @(negedge clk);
    req(1, 0, 32'h8000_0002, 2, 0);
    #1;
    chk("mis_man_vld", man_vld, 0);
    chk("mis_sub_rdy", sub_rdy, 1);
    @(negedge clk);
    req(0, 0, 0, 0, 0);
    #1;
    chk("mis_sub_err", sub_err, 1);
    chk("mis_sub_rdt", sub_rdt, 0);
    @(negedge clk);
    req(1, 0, 32'h8000_0004, 2, 0);
    #1;
    chk("mis_after_vld", man_vld, 1);
    chk("mis_after_ben", man_ben, 4'b1111);
    @(negedge clk);
    req(0, 0, 0, 0, 0);
    #1;
    chk("mis_after_rdt", sub_rdt, 32'hAAAD_BEEF);
    chk("mis_after_err", sub_err, 0);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
